// File: rtl/bram_delay_ctrl.sv
// Single-port word store with a fixed-latency read return path.
// Read data and destination tag travel through a DELAYS-deep delay line to the CPU or DMA port.
module bram_delay_ctrl #(
    parameter int unsigned DELAYS = 10,
    parameter int unsigned ADDR_W = 13
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              in_valid,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data_in,
    input  logic              reader_sel,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_get_data,
    output logic [31:0]       dma_data_o,
    output logic              dma_get_data,
    output logic [4:0]        pending_cnt
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    // Registers between the storage read and the output registers.
    localparam int unsigned PIPE_N = (DELAYS > 1) ? DELAYS - 1 : 1;

    typedef struct packed {
        logic              vld;
        logic              sel;
        logic [DATA_W-1:0] data;
    } stage_t;

    if (DELAYS < 1 || DELAYS > 31) begin : g_bad_delays
        $error("bram_delay_ctrl: DELAYS must be within 1..31");
    end
    if (ADDR_W < 1) begin : g_bad_addr_w
        $error("bram_delay_ctrl: ADDR_W must be at least 1");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic       wr_en_c;
    logic       rd_en_c;
    logic       ret_now_c;
    logic [CNT_W-1:0] cnt_nxt_c;
    stage_t     head_c;
    stage_t     tail_c;

    // Requests are ignored while reset is held.
    always_comb begin
        wr_en_c   = in_valid & wr & ~wb_rst_i;
        rd_en_c   = in_valid & ~wr & ~wb_rst_i;
        ret_now_c = cpu_get_data | dma_get_data;
    end

    // Storage is never reset; contents persist across wb_rst_i.
    always_ff @(posedge wb_clk_i) begin
        if (wr_en_c) begin
            mem[addr] <= data_in;
        end
    end

    // Read-before-write: a read samples the word as it stood before this cycle's edge.
    always_comb begin
        head_c      = '0;
        head_c.vld  = rd_en_c;
        head_c.sel  = reader_sel;
        head_c.data = mem[addr];
    end

    if (DELAYS == 1) begin : g_direct
        assign tail_c = head_c;
    end else begin : g_pipe
        stage_t pipe_q [PIPE_N];

        always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
            if (wb_rst_i) begin
                for (int unsigned i = 0; i < PIPE_N; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                pipe_q[0] <= head_c;
                for (int unsigned i = 1; i < PIPE_N; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign tail_c = pipe_q[PIPE_N-1];
    end

    // In-flight read count: an accept and a return in the same cycle cancel.
    always_comb begin
        cnt_nxt_c = pending_cnt;
        case ({rd_en_c, ret_now_c})
            2'b10:   cnt_nxt_c = pending_cnt + CNT_W'(1);
            2'b01:   cnt_nxt_c = pending_cnt - CNT_W'(1);
            default: cnt_nxt_c = pending_cnt;
        endcase
    end

    // Return registers; data holds its last value between pulses.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cpu_get_data <= 1'b0;
            dma_get_data <= 1'b0;
            cpu_data_o   <= '0;
            dma_data_o   <= '0;
            pending_cnt  <= '0;
        end else begin
            cpu_get_data <= tail_c.vld & tail_c.sel;
            dma_get_data <= tail_c.vld & ~tail_c.sel;
            if (tail_c.vld & tail_c.sel) begin
                cpu_data_o <= tail_c.data;
            end
            if (tail_c.vld & ~tail_c.sel) begin
                dma_data_o <= tail_c.data;
            end
            pending_cnt <= cnt_nxt_c;
        end
    end

    a_one_dest: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
        !(cpu_get_data && dma_get_data));
    a_cnt_bound: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
        pending_cnt <= CNT_W'(DELAYS));
    a_no_underflow: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
        !(pending_cnt == '0 && ret_now_c));

endmodule
